// File: rtl/pcie_s10_msi_sched_pkg.sv
// rtl/pcie_s10_msi_sched_pkg.sv - shared constants and helpers for the MSI scheduler
package pcie_s10_msi_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int         MSI_NUM_WIDTH = 5;
  localparam logic [2:0] MSI_TC        = 3'd0;

  // Host grants 2**mme vectors; anything above 32 vectors is capped at 5 bits.
  function automatic logic [MSI_NUM_WIDTH-1:0] vec_mask(input logic [2:0] mme);
    logic [2:0] m;
    m = (mme > 3'd5) ? 3'd5 : mme;
    return MSI_NUM_WIDTH'((6'd1 << m) - 6'd1);
  endfunction

endpackage

// File: rtl/pcie_s10_msi_sched_rr_prio_encoder.sv
// rtl/pcie_s10_msi_sched_rr_prio_encoder.sv - round-robin first-set search starting at a pointer
module rr_prio_encoder #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set bit at/after ptr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_s10_msi_sched.sv
// rtl/pcie_s10_msi_sched.sv - round-robin scheduler of interrupt sources onto the single MSI port
module pcie_s10_msi_sched
  import pcie_s10_msi_sched_pkg::*;
#(
  parameter int IRQ_COUNT   = 32,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IRQ_COUNT-1:0]     irq,
  input  logic                     msi_enable,
  input  logic [IRQ_COUNT-1:0]     msi_mask,
  input  logic [2:0]               msi_mme,
  input  logic [1:0]               msi_func_num,
  output logic                     app_msi_req,
  input  logic                     app_msi_ack,
  output logic [2:0]               app_msi_tc,
  output logic [MSI_NUM_WIDTH-1:0] app_msi_num,
  output logic [1:0]               app_msi_func_num,
  output logic [IRQ_COUNT-1:0]     irq_pending,
  output logic                     msi_timeout
);

  localparam int IW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int TW = $clog2(ACK_TIMEOUT + 2);

  logic [1:0]           state;
  logic [IW-1:0]        rr;
  logic [IW-1:0]        sel;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [IW-1:0]        rr_after;
  logic [IRQ_COUNT-1:0] pending;
  logic [IRQ_COUNT-1:0] clr;
  logic [GW-1:0]        gap_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 ack_hit;
  logic                 to_hit;

  rr_prio_encoder #(
    .N  (IRQ_COUNT),
    .IW (IW)
  ) u_enc (
    .req   (pending & ~msi_mask),
    .ptr   (rr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign ack_hit  = (state == ST_REQ) && app_msi_ack;
  assign to_hit   = (ACK_TIMEOUT != 0) && (state == ST_REQ) && !app_msi_ack &&
                    (to_cnt == TW'(ACK_TIMEOUT - 1));
  assign rr_after = (sel == IW'(IRQ_COUNT - 1)) ? '0 : sel + IW'(1);

  // Only an ack retires a source; a fresh pulse in the same cycle re-arms it.
  always_comb begin
    clr = '0;
    if (ack_hit) clr[sel] = 1'b1;
  end

  assign app_msi_tc  = MSI_TC;
  assign irq_pending = pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      rr               <= '0;
      sel              <= '0;
      pending          <= '0;
      gap_cnt          <= '0;
      to_cnt           <= '0;
      app_msi_req      <= 1'b0;
      app_msi_num      <= '0;
      app_msi_func_num <= '0;
      msi_timeout      <= 1'b0;
    end else begin
      pending     <= (pending & ~clr) | irq;
      msi_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (msi_enable && pick_valid) begin
            sel              <= pick_idx;
            app_msi_req      <= 1'b1;
            app_msi_num      <= MSI_NUM_WIDTH'(pick_idx) & vec_mask(msi_mme);
            app_msi_func_num <= msi_func_num;
            to_cnt           <= '0;
            state            <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Enable/mask changes are deliberately ignored here; a request is never withdrawn.
          if (app_msi_ack || to_hit) begin
            app_msi_req <= 1'b0;
            rr          <= rr_after;
            msi_timeout <= to_hit;
            gap_cnt     <= '0;
            state       <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_s10_msi_sched.sv
// tb/tb_pcie_s10_msi_sched.sv - directed and randomized bench for pcie_s10_msi_sched
module tb_pcie_s10_msi_sched;

  localparam int N   = 32;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq = '0;
  logic         msi_enable = 1'b0;
  logic [N-1:0] msi_mask = '0;
  logic [2:0]   msi_mme = 3'd0;
  logic [1:0]   msi_func_num = 2'd0;
  logic         app_msi_req;
  logic         app_msi_ack = 1'b0;
  logic [2:0]   app_msi_tc;
  logic [4:0]   app_msi_num;
  logic [1:0]   app_msi_func_num;
  logic [N-1:0] irq_pending;
  logic         msi_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] m_pend = '0;
  int           m_rr   = 0;

  always #5 clk = ~clk;

  pcie_s10_msi_sched #(
    .IRQ_COUNT   (N),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq              (irq),
    .msi_enable       (msi_enable),
    .msi_mask         (msi_mask),
    .msi_mme          (msi_mme),
    .msi_func_num     (msi_func_num),
    .app_msi_req      (app_msi_req),
    .app_msi_ack      (app_msi_ack),
    .app_msi_tc       (app_msi_tc),
    .app_msi_num      (app_msi_num),
    .app_msi_func_num (app_msi_func_num),
    .irq_pending      (irq_pending),
    .msi_timeout      (msi_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int rr);
    for (int k = 0; k < N; k++)
      if (elig[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int exp_num(input int src);
    int m;
    m = (msi_mme > 3'd5) ? 5 : int'(msi_mme);
    return src % (1 << m);
  endfunction

  task automatic pulse(input logic [N-1:0] bits);
    irq = bits;
    m_pend |= bits;
    tick();
    irq = '0;
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (!app_msi_req && waited < 100) begin
      tick();
      waited++;
    end
    check("req_rise", app_msi_req, 1'b1);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (app_msi_req) seen++;
    end
    check(tag, seen, 0);
  endtask

  // One MSI handshake: checks the issued vector against the model, acks after ack_dly cycles.
  task automatic serve(input int ack_dly, input logic [N-1:0] p_dur, input bit repulse,
                       input logic [N-1:0] p_ack, output int src, output int idle);
    logic [N-1:0] at_ack;
    wait_req(idle);
    src = pick(m_pend & ~msi_mask, m_rr);
    check("msi_num", app_msi_num, exp_num(src));
    check("msi_func", app_msi_func_num, msi_func_num);
    check("msi_tc", app_msi_tc, 3'd0);
    for (int d = 0; d < ack_dly; d++) begin
      irq = (d == 0) ? p_dur : '0;
      m_pend |= irq;
      tick();
      if (!app_msi_req || app_msi_num != exp_num(src)) check("req_held", {app_msi_req, app_msi_num}, {1'b1, 5'(exp_num(src))});
    end
    at_ack = p_ack | (repulse ? (N'(1) << src) : '0);
    irq = at_ack;
    app_msi_ack = 1'b1;
    tick();
    irq = '0;
    app_msi_ack = 1'b0;
    m_pend = (m_pend & ~(N'(1) << src)) | at_ack;
    m_rr = (src + 1) % N;
    check("req_drop", app_msi_req, 1'b0);
    check("pending", irq_pending, m_pend);
  endtask

  initial begin
    int src, idle, cnt, idx;
    logic [N-1:0] bits;

    tick();
    tick();
    check("rst_req", app_msi_req, 1'b0);
    check("rst_num", app_msi_num, 5'd0);
    check("rst_func", app_msi_func_num, 2'd0);
    check("rst_pend", irq_pending, '0);
    check("rst_to", msi_timeout, 1'b0);
    rst_n = 1'b1;
    msi_enable = 1'b1;
    msi_mme = 3'd5;
    msi_func_num = 2'd2;
    tick();

    // Three simultaneous sources drain in index order from rr=0 with gaps between.
    pulse((N'(1) << 2) | (N'(1) << 7) | (N'(1) << 30));
    serve(0, '0, 1'b0, '0, src, idle);
    check("t2_first", src, 2);
    serve(0, '0, 1'b0, '0, src, idle);
    check("t2_second", src, 7);
    check("t2_gap1", idle >= GAP, 1'b1);
    serve(0, '0, 1'b0, '0, src, idle);
    check("t2_third", src, 30);
    check("t2_gap2", idle >= GAP, 1'b1);

    pulse(N'(1) << 3);
    serve(3, '0, 1'b0, '0, src, idle);
    check("t1_src", src, 3);
    check("t1_pend3", irq_pending[3], 1'b0);
    quiet(20, "t1_single");

    msi_mask = N'(1) << 5;
    pulse(N'(1) << 5);
    quiet(12, "t3_masked");
    check("t3_pend5", irq_pending[5], 1'b1);
    msi_mask = '0;
    serve(1, '0, 1'b0, '0, src, idle);
    check("t3_src", src, 5);

    msi_enable = 1'b0;
    pulse(N'(1) << 11);
    quiet(12, "dis_quiet");
    check("dis_pend", irq_pending, m_pend);
    msi_enable = 1'b1;
    serve(2, '0, 1'b0, '0, src, idle);
    check("dis_src", src, 11);

    msi_mme = 3'd1;
    pulse(N'(1) << 6);
    serve(1, '0, 1'b0, '0, src, idle);
    check("t4_num6", app_msi_num, 5'd0);
    pulse(N'(1) << 7);
    wait_req(idle);
    check("t4_num7", app_msi_num, 5'd1);
    serve(0, '0, 1'b0, '0, src, idle);
    msi_mme = 3'd5;

    pulse(N'(1) << 4);
    serve(2, '0, 1'b1, '0, src, idle);
    check("t5_keep", irq_pending[4], 1'b1);
    serve(0, '0, 1'b0, '0, src, idle);
    check("t5_src", src, 4);
    check("t5_gap", idle >= GAP, 1'b1);

    // Random traffic: mask/mme only change right after an ack, while the DUT is in its gap.
    for (int it = 0; it < 60; it++) begin
      if ((m_pend & ~msi_mask) == '0) begin
        do idx = $urandom_range(0, N - 1); while (msi_mask[idx]);
        bits = ($urandom & $urandom & $urandom) | (N'(1) << idx);
        pulse(bits);
      end
      serve($urandom_range(0, 6), $urandom & $urandom & $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0, src, idle);
      check("rnd_gap", idle >= GAP || it == 0, 1'b1);
      msi_mask = $urandom & $urandom & 32'h7fff_ffff;
      msi_mme = 3'($urandom_range(0, 7));
      msi_func_num = 2'($urandom_range(0, 3));
    end
    msi_mask = '0;
    cnt = 0;
    while (m_pend != '0 && cnt < 40) begin
      serve($urandom_range(0, 3), '0, 1'b0, '0, src, idle);
      cnt++;
    end
    check("drain", m_pend == '0, 1'b1);
    quiet(12, "drain_quiet");
    msi_mme = 3'd5;

    pulse(N'(1) << 9);
    wait_req(idle);
    check("t6_num", app_msi_num, 5'd9);
    cnt = 0;
    while (app_msi_req && cnt < 40) begin
      tick();
      cnt++;
    end
    check("t6_req_len", cnt, TO);
    check("t6_to_pulse", msi_timeout, 1'b1);
    m_rr = 10;
    tick();
    check("t6_to_clear", msi_timeout, 1'b0);
    check("t6_pend_kept", irq_pending, m_pend);
    wait_req(idle);
    check("t6_reissue", app_msi_num, 5'd9);
    pulse(N'(1) << 20);
    check("t6_req_still", app_msi_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", app_msi_req, 1'b0);
    check("rst_mid_pend", irq_pending, '0);
    m_pend = '0;
    m_rr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse(N'(1) << 1);
    serve(1, '0, 1'b0, '0, src, idle);
    check("post_rst_src", src, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
